// File: rtl/key_load_pkg.sv
// Shared types and the serial CRC-8 step for the key-load controller and its bench.
package key_load_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_KEY,
        SHIFT_CRC,
        CHECK,
        APPLIED,
        ERROR,
        LOCKOUT
    } state_t;

    localparam int unsigned CRC_W = 8;
    localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;

    // One bit of MSB-first CRC-8, init 0, no reflection, no final xor.
    function automatic logic [CRC_W-1:0] crc8_step(
        input logic [CRC_W-1:0] crc,
        input logic             din,
        input logic [CRC_W-1:0] poly = CRC_POLY
    );
        crc8_step = {crc[CRC_W-2:0], 1'b0} ^ ((crc[CRC_W-1] ^ din) ? poly : '0);
    endfunction

endpackage

// File: rtl/key_crc8_serial.sv
// Serial CRC-8 accumulator with synchronous clear and per-bit enable.
module key_crc8_serial
    import key_load_pkg::*;
#(
    parameter logic [CRC_W-1:0] POLY = CRC_POLY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [CRC_W-1:0] crc
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= crc8_step(crc, din, POLY);
        end
    end

endmodule

// File: rtl/key_load_ctrl.sv
// Bit-serial key loader: shifts key + CRC-8, applies key atomically on CRC pass.
// Optional macro KEY_LOCKOUT_EN adds a permanent lockout after MAX_FAIL consecutive CRC failures.
module key_load_ctrl
    import key_load_pkg::*;
#(
    parameter int unsigned            KEY_WIDTH = 32,
    parameter logic [KEY_WIDTH-1:0]   DECOY_KEY = '0,
    parameter logic [CRC_W-1:0]       CRC_POLY  = key_load_pkg::CRC_POLY,
    parameter int unsigned            MAX_FAIL  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 key_sdata,
    input  logic                 key_svalid,
    output logic                 key_sready,
    output logic [KEY_WIDTH-1:0] key_out,
    output logic                 key_valid,
    output logic                 busy,
    output logic                 crc_err,
    output logic                 locked_out
);

    localparam int unsigned CNT_W = $clog2(KEY_WIDTH);

    state_t               state, next_state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [KEY_WIDTH-1:0] shadow;
    logic [CRC_W-1:0]     rx_crc;
    logic [CRC_W-1:0]     crc;
    logic                 hs, start_ok, crc_en, key_last, crc_last, crc_pass, go_lockout;

    assign hs       = key_svalid && key_sready;
    assign key_last = (bit_cnt == CNT_W'(KEY_WIDTH - 1));
    assign crc_last = (bit_cnt == CNT_W'(CRC_W - 1));
    assign crc_pass = (rx_crc == crc);

    key_crc8_serial #(.POLY(CRC_POLY)) u_crc (
        .clk (clk),
        .rst (rst),
        .clr (start_ok),
        .en  (crc_en),
        .din (key_sdata),
        .crc (crc)
    );

`ifdef KEY_LOCKOUT_EN
    localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);
    logic [FAIL_W-1:0] fail_cnt;

    assign go_lockout = (32'(fail_cnt) + 32'd1 >= MAX_FAIL);

    always_ff @(posedge clk) begin
        if (rst) begin
            fail_cnt <= '0;
        end else if (state == CHECK) begin
            if (crc_pass) begin
                fail_cnt <= '0;
            end else if (fail_cnt != FAIL_W'(MAX_FAIL)) begin
                fail_cnt <= fail_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            locked_out <= 1'b0;
        end else begin
            locked_out <= (next_state == LOCKOUT);
        end
    end
`else
    assign go_lockout = 1'b0;
    assign locked_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE, APPLIED, ERROR: if (start) next_state = SHIFT_KEY;
            SHIFT_KEY:            if (hs && key_last) next_state = SHIFT_CRC;
            SHIFT_CRC:            if (hs && crc_last) next_state = CHECK;
            CHECK: begin
                if (crc_pass)        next_state = APPLIED;
                else if (go_lockout) next_state = LOCKOUT;
                else                 next_state = ERROR;
            end
            LOCKOUT:              next_state = LOCKOUT;
            default:              next_state = IDLE;
        endcase
    end

    always_comb begin
        key_sready = (state == SHIFT_KEY) || (state == SHIFT_CRC);
        start_ok   = start && ((state == IDLE) || (state == APPLIED) || (state == ERROR));
        crc_en     = hs && (state == SHIFT_KEY);
    end

    // key_out only ever takes a complete, CRC-checked shadow; partial loads stay internal.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            shadow    <= '0;
            rx_crc    <= '0;
            key_out   <= DECOY_KEY;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            crc_err   <= 1'b0;
        end else begin
            busy <= (next_state inside {SHIFT_KEY, SHIFT_CRC, CHECK});
            if (start_ok) begin
                shadow  <= '0;
                rx_crc  <= '0;
                bit_cnt <= '0;
                crc_err <= 1'b0;
            end
            if (hs) begin
                if (state == SHIFT_KEY) begin
                    shadow[bit_cnt] <= key_sdata;
                end else begin
                    rx_crc <= {rx_crc[CRC_W-2:0], key_sdata};
                end
                if ((state == SHIFT_KEY && key_last) || (state == SHIFT_CRC && crc_last)) begin
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            if (state == CHECK) begin
                if (crc_pass) begin
                    key_out   <= shadow;
                    key_valid <= 1'b1;
                end else begin
                    crc_err <= 1'b1;
                    if (go_lockout) begin
                        key_out   <= DECOY_KEY;
                        key_valid <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_key_load_ctrl.sv
// Self-checking bench for key_load_ctrl: transaction-level model compared every cycle plus literal pins.
module tb_key_load_ctrl;
    import key_load_pkg::*;

    localparam int unsigned KW = 32;
    localparam logic [KW-1:0] DECOY = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          key_sdata = 1'b0;
    logic          key_svalid = 1'b0;
    logic          key_sready, key_valid, busy, crc_err, locked_out;
    logic [KW-1:0] key_out;

    key_load_ctrl #(
        .KEY_WIDTH (KW),
        .DECOY_KEY (DECOY),
        .CRC_POLY  (8'h07),
        .MAX_FAIL  (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key_sdata  (key_sdata),
        .key_svalid (key_svalid),
        .key_sready (key_sready),
        .key_out    (key_out),
        .key_valid  (key_valid),
        .busy       (busy),
        .crc_err    (crc_err),
        .locked_out (locked_out)
    );

    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    bit          chk_en  = 1'b0;

    // Expected observable state, advanced one transaction step at a time.
    logic [KW-1:0] m_key;
    logic          m_valid, m_err, m_busy, m_sready, m_lock;
    int            m_fails;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("key_out",    64'(key_out),    64'(m_key));
            check("key_valid",  64'(key_valid),  64'(m_valid));
            check("crc_err",    64'(crc_err),    64'(m_err));
            check("busy",       64'(busy),       64'(m_busy));
            check("key_sready", 64'(key_sready), 64'(m_sready));
            check("locked_out", 64'(locked_out), 64'(m_lock));
        end
    end

    function automatic logic [7:0] ref_crc(input logic [KW-1:0] key);
        logic [7:0] c;
        c = '0;
        for (int i = 0; i < int'(KW); i++) c = crc8_step(c, key[i]);
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; key_svalid = 1'b0; key_sdata = 1'b0;
        tick();
        rst = 1'b0;
        m_key = DECOY; m_valid = 1'b0; m_err = 1'b0; m_busy = 1'b0;
        m_sready = 1'b0; m_lock = 1'b0; m_fails = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        if (!m_busy && !m_lock) begin
            m_busy = 1'b1; m_sready = 1'b1; m_err = 1'b0;
        end
    endtask

    // idle_pct: chance of an idle (svalid=0) cycle before each bit; noise adds start pulses while busy.
    task automatic send_bit(input logic b, input int unsigned idle_pct, input bit start_too);
        int unsigned n;
        n = 0;
        while ($urandom_range(99) < idle_pct && n < 20) begin
            key_svalid = 1'b0; key_sdata = 1'($urandom);
            tick();
            n++;
        end
        key_svalid = 1'b1; key_sdata = b; start = start_too;
        tick();
        key_svalid = 1'b0; start = 1'b0;
    endtask

    task automatic load(input logic [KW-1:0] key, input logic [7:0] crc,
                        input int unsigned idle_pct, input bit noise);
        do_start();
        for (int i = 0; i < int'(KW); i++) begin
            if (noise && i == 20) do_start();
            send_bit(key[i], idle_pct, noise && (i == 10));
        end
        for (int i = 7; i >= 0; i--) send_bit(crc[i], idle_pct, 1'b0);
        m_sready = 1'b0;
        tick();
        m_busy = 1'b0;
        if (crc == ref_crc(key)) begin
            m_key = key; m_valid = 1'b1; m_fails = 0;
        end else begin
            m_err = 1'b1;
            m_fails++;
`ifdef KEY_LOCKOUT_EN
            if (m_fails >= 3) begin
                m_lock = 1'b1; m_key = DECOY; m_valid = 1'b0;
            end
`endif
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        chk_en = 1'b1;
        check("reset_key_out", 64'(key_out), 64'h0);
        check("crc_of_0",      64'(ref_crc(32'h0000_0000)), 64'h00);
        check("crc_of_msb",    64'(ref_crc(32'h8000_0000)), 64'h07);
        check("crc_of_bit30",  64'(ref_crc(32'h4000_0000)), 64'h0E);

        // All-zero key with zero CRC
        load(32'h0000_0000, 8'h00, 0, 1'b0);
        check("t1_valid", 64'(key_valid), 64'h1);
        check("t1_err",   64'(crc_err),   64'h0);

        // Pass, then reload keeps old key until CHECK
        load(32'h8000_0000, 8'h07, 0, 1'b0);
        check("t2_key_a", 64'(key_out), 64'h8000_0000);
        load(32'h4000_0000, 8'h0E, 0, 1'b0);
        check("t2_key_b", 64'(key_out), 64'h4000_0000);

        // Bad CRC keeps key, new start clears crc_err
        load(32'h4000_0000, 8'h07, 0, 1'b0);
        check("t3_err", 64'(crc_err), 64'h1);
        check("t3_key", 64'(key_out), 64'h4000_0000);
        do_start();
        check("t3_err_clr", 64'(crc_err), 64'h0);
        do_reset();

        // Sparse valid, start pulses while busy, then reset mid-load
        load(32'hA5C3_0F96, ref_crc(32'hA5C3_0F96), 70, 1'b1);
        check("t4_key", 64'(key_out), 64'hA5C3_0F96);
        do_start();
        for (int i = 0; i < 17; i++) send_bit(1'b1, 70, i == 3);
        do_reset();
        check("t4_rst_key",   64'(key_out),   64'(DECOY));
        check("t4_rst_valid", 64'(key_valid), 64'h0);

        // Three consecutive CRC failures
        load(32'h1234_5678, ref_crc(32'h1234_5678), 0, 1'b0);
        for (int k = 0; k < 3; k++)
            load(32'hCAFE_0000 + 32'(k), ref_crc(32'hCAFE_0000 + 32'(k)) ^ 8'h5A, 0, 1'b0);
`ifdef KEY_LOCKOUT_EN
        check("t5_locked", 64'(locked_out), 64'h1);
        check("t5_decoy",  64'(key_out),    64'(DECOY));
        do_start();
        check("t5_start_ignored", 64'(busy), 64'h0);
        do_reset();
        check("t5_unlocked", 64'(locked_out), 64'h0);
`else
        check("t5_not_locked", 64'(locked_out), 64'h0);
        load(32'h0BAD_F00D, ref_crc(32'h0BAD_F00D), 0, 1'b0);
        check("t5_fourth_ok", 64'(key_out), 64'h0BAD_F00D);
        check("t5_err_clr",   64'(crc_err), 64'h0);
`endif

        // Random keys with correct CRC
        for (int k = 0; k < 1000; k++) begin
            logic [KW-1:0] key;
            key = $urandom;
            load(key, ref_crc(key), 0, 1'b0);
        end

        tick();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
